// File: rtl/sobel_gray_stream_tx_if.sv
// Pixel stream bundle for the Sobel front end.
// Carries the source RGB pixel handshake (in_*) and the gray+RGB output handshake (m_*, eol, eof).
// Modports: master = the converter block; slave = the environment (source and line buffer).
interface sobel_gray_stream_tx_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_rgb;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  data_m_gray;
    logic [23:0] data_m_rgb;
    logic        eol;
    logic        eof;

    modport master (
        input  in_valid, in_rgb, m_ready,
        output in_ready, m_valid, data_m_gray, data_m_rgb, eol, eof
    );

    modport slave (
        output in_valid, in_rgb, m_ready,
        input  in_ready, m_valid, data_m_gray, data_m_rgb, eol, eof
    );
endinterface

// File: rtl/sobel_gray_stream_tx.sv
// Purpose: RGB888 -> 8-bit luma converter framing one IMG_W x IMG_H image per start pulse.
// Latency: 2 cycles from input handshake to m_valid, 1 pixel/clk when unstalled.
// Backpressure: m_ready stalls stage 2; in_ready drops once both stages are full.
// Ports: clk, rst_n (async active-low), start, busy, frame_done; bus = stream interface (master).
// Option: define SOBEL_GRAY_ROUND_EN for round-to-nearest luma instead of truncation.
module sobel_gray_stream_tx #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic frame_done,
    sobel_gray_stream_tx_if.master bus
);

    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int PIX_W     = $clog2(FRAME_PIX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [PIX_W-1:0] in_cnt;
    logic [CNT_W-1:0] col, row;

    logic        v1, v2;
    logic [15:0] pr, pg, pb;
    logic [23:0] rgb1, rgb2;
    logic [7:0]  gray2;
    logic [15:0] sum;

    logic in_rdy, in_hs, out_hs, ld2, eol_i, eof_i;

    // Ready chain: stage 1 can take a pixel if it is empty, or stage 2 is
    // empty, or stage 2 is draining this cycle.
    assign in_rdy = (state == S_RUN) && (in_cnt < PIX_W'(FRAME_PIX))
                    && (!v1 || !v2 || bus.m_ready);
    assign in_hs  = bus.in_valid && in_rdy;
    assign out_hs = v2 && bus.m_ready;
    assign ld2    = v1 && (!v2 || bus.m_ready);

`ifdef SOBEL_GRAY_ROUND_EN
    assign sum = pr + pg + pb + 16'd128;
`else
    assign sum = pr + pg + pb;
`endif

    assign eol_i = v2 && (col == CNT_W'(IMG_W - 1));
    assign eof_i = eol_i && (row == CNT_W'(IMG_H - 1));

    assign bus.in_ready    = in_rdy;
    assign bus.m_valid     = v2;
    assign bus.data_m_gray = gray2;
    assign bus.data_m_rgb  = rgb2;
    assign bus.eol         = eol_i;
    assign bus.eof         = eof_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (in_cnt == PIX_W'(FRAME_PIX)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (out_hs && eof_i) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame counters: in_cnt tracks acceptances, col/row track delivered beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt <= '0;
            col    <= '0;
            row    <= '0;
        end else if (state == S_IDLE && start) begin
            in_cnt <= '0;
            col    <= '0;
            row    <= '0;
        end else begin
            if (in_hs) in_cnt <= in_cnt + PIX_W'(1);
            if (out_hs) begin
                if (col == CNT_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == CNT_W'(IMG_H - 1)) ? '0 : row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
            end
        end
    end

    // Two-stage luma pipeline; stage 2 doubles as the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            pr    <= '0;
            pg    <= '0;
            pb    <= '0;
            rgb1  <= '0;
            rgb2  <= '0;
            gray2 <= '0;
        end else begin
            if (in_hs) begin
                v1   <= 1'b1;
                pr   <= 16'(bus.in_rgb[23:16]) * 16'd77;
                pg   <= 16'(bus.in_rgb[15:8])  * 16'd150;
                pb   <= 16'(bus.in_rgb[7:0])   * 16'd29;
                rgb1 <= bus.in_rgb;
            end else if (ld2) begin
                v1 <= 1'b0;
            end

            if (ld2) begin
                v2    <= 1'b1;
                gray2 <= 8'(sum >> 8);
                rgb2  <= rgb1;
            end else if (out_hs) begin
                v2 <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sobel_gray_stream_tx.md
Name: sobel_gray_stream_tx

Overview:
- Upstream master for the Sobel line-buffer stage.
- Accepts a raw RGB888 pixel stream and converts each pixel to 8-bit luma through a 2-stage pipeline.
- Drives the valid/ready pixel interface (gray plus delayed RGB) consumed by the line buffer, honouring its backpressure.
- Frames one image of IMG_W x IMG_H pixels per start pulse, and flags end-of-line and end-of-frame.

Parameters:
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame.
- CNT_W, 12: width of the column/row counters. Must satisfy 2^CNT_W > max(IMG_W, IMG_H).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when in IDLE.
- in_valid  in  1  source RGB pixel valid.
- in_ready  out  1  block accepts source pixel.
- in_rgb  in  24  {R[23:16], G[15:8], B[7:0]}.
- m_valid  out  1  output pixel valid towards the line buffer.
- m_ready  in  1  line buffer ready (backpressure).
- data_m_gray  out  8  luma.
- data_m_rgb  out  24  RGB aligned with data_m_gray.
- eol  out  1  current output pixel is the last of its line.
- eof  out  1  current output pixel is the last of the frame.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE and all stage valids to 0;
  - all counters to 0;
  - m_valid, eol, eof, busy, frame_done to 0;
  - data_m_gray = 0 and data_m_rgb = 0.
- Reset asserted mid-frame discards all in-flight pixels. No frame_done pulse is produced.
- Handshakes:
  - Input handshake: in_valid & in_ready.
  - Output handshake: m_valid & m_ready.
  - m_valid, once high, stays high with data stable until m_ready is sampled high.
- Pipeline:
  - Stage 1 registers pR=77*R, pG=150*G, pB=29*B (16 bits each) plus the RGB.
  - Stage 2 registers gray = (pR+pG+pB)[15:8] plus the RGB. Stage 2 is the output register (m_valid = v2).
  - Load rules: ld2 = v1 & (~v2 | m_ready); ld1 = in handshake.
  - in_ready = (state==RUN) & (in_cnt < IMG_W*IMG_H) & (~v1 | ~v2 | m_ready). This is a combinational ready chain; no bubbles while m_ready stays high.
  - Latency: 2 cycles from input handshake to m_valid when unstalled. Throughput is 1 pixel/clk.
- Arithmetic: sum max 65280 fits 16 bits; no saturation is needed.
- Counters:
  - in_cnt counts input handshakes in the frame.
  - col and row advance on output handshake only. col wraps IMG_W-1 -> 0 and then increments row; row wraps IMG_H-1 -> 0.
  - eol = m_valid & (col==IMG_W-1).
  - eof = eol & (row==IMG_H-1).
- FSM:
  - IDLE: in_ready=0. start -> RUN, clearing in_cnt/col/row.
  - RUN: accept pixels. When in_cnt reaches IMG_W*IMG_H -> DRAIN.
  - DRAIN: in_ready=0. Output handshake with eof=1 -> DONE.
  - DONE: frame_done=1 for one cycle, then -> IDLE.
  - start outside IDLE is ignored.
- Simultaneous events:
  - A stage-2 pixel leaving and a stage-1 pixel entering stage 2 in the same cycle is legal.
  - An input accepted on the same cycle as the last in_cnt increment is counted, and the FSM moves to DRAIN on the next edge.
- Stalls: with m_ready=0 for any number of cycles:
  - at most 2 pixels are held;
  - no data is lost or duplicated;
  - in_ready falls once both stages are full.

Optional Feature:
- Macro: SOBEL_GRAY_ROUND_EN.
- Defined: stage 2 computes gray = (pR+pG+pB+128)[15:8], i.e. round-to-nearest. Max 65408 still fits 16 bits.
- Undefined: truncation, as described above.

Test Plan:
- Pure-colour pixels with m_ready=1, in_valid=1:
  - (255,255,255) -> gray 255;
  - (255,0,0) -> 76 (77 with SOBEL_GRAY_ROUND_EN);
  - (0,255,0) -> 149 (149 with round);
  - (0,0,255) -> 28 (29 with round).
  - Each appears 2 cycles after acceptance.
- IMG_W=4, IMG_H=2, start, continuous input 0..7 with m_ready=1:
  - 8 output beats;
  - eol on beats 3 and 7; eof on beat 7 only;
  - frame_done 1 cycle after beat 7; busy low afterwards.
- Random m_ready (50%) and random in_valid over a full frame:
  - output sequence equals the input sequence, no drop or duplicate;
  - data_m_rgb/data_m_gray are stable while m_valid & ~m_ready.
- m_ready held 0 for 10 cycles during RUN:
  - exactly 2 pixels are accepted, then in_ready=0;
  - on release, pixels stream out in order at 1/clk.
- Extra in_valid after 8 pixels in the 4x2 frame: in_ready=0 and in_cnt stays at 8. start pulse during RUN: ignored.
- rst_n asserted mid-frame with both stages full:
  - m_valid=0 immediately (async), state IDLE, no frame_done;
  - a new start then produces a clean frame from col=0, row=0.
